// File: rtl/uart_mmio.sv
// uart_mmio: memory-mapped 8N1 UART with TXD/RXD/CON registers and a registered level IRQ.
module uart_mmio #(
  parameter int          BAUD_DIV = 5208,
  parameter logic [31:0] BASE     = 32'h40000018
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rd,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic        uart_rx,
  output logic        uart_tx,
  output logic        irq
);
  localparam int CW = $clog2(BAUD_DIV);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t r_tx_st, w_tx_nst, r_rx_st, w_rx_nst;
  logic [CW-1:0] r_tx_cnt, w_tx_ncnt, r_rx_cnt, w_rx_ncnt;
  logic [2:0] r_tx_bit, w_tx_nbit, r_rx_bit, w_rx_nbit;
  logic [7:0] r_tx_data, r_rx_data, r_rx_sh, w_rx_nsh;
  logic [1:0] r_en;
  logic r_tx_done, r_rx_valid, r_ovr, r_irq, r_s1, r_s2, r_s3;
  logic w_tx_fin, w_rx_done;
  wire w_txd_hit = addr == BASE;
  wire w_rxd_hit = addr == BASE + 32'd4;
  wire w_con_hit = addr == BASE + 32'd8;
  wire w_busy    = r_tx_st != IDLE;
  wire w_tx_go   = wr & w_txd_hit & ~w_busy;
  wire w_rxd_rd  = rd & w_rxd_hit;
  wire w_con_rd  = rd & w_con_hit;
  wire w_tx_tick = r_tx_cnt == CW'(BAUD_DIV - 1);
  wire w_rx_tick = r_rx_cnt == '0;
  wire w_rx_fall = r_s3 & ~r_s2;
  wire w_unused  = &{1'b0, wdata[31:8]};
  assign uart_tx = (r_tx_st == START) ? 1'b0 : (r_tx_st == DATA) ? r_tx_data[r_tx_bit] : 1'b1;
  assign irq     = r_irq;
  assign rdata   = !rd       ? 32'h0 :
                   w_txd_hit ? {24'h0, r_tx_data} :
                   w_rxd_hit ? {24'h0, r_rx_data} :
                   w_con_hit ? {26'h0, r_ovr, w_busy, r_rx_valid, r_tx_done, r_en} : 32'h0;
  always_comb begin
    w_tx_nst  = r_tx_st;
    w_tx_ncnt = w_tx_tick ? '0 : r_tx_cnt + 1'b1;
    w_tx_nbit = r_tx_bit;
    w_tx_fin  = 1'b0;
    case (r_tx_st)
      IDLE: begin
        w_tx_ncnt = '0;
        if (w_tx_go) w_tx_nst = START;
      end
      START: if (w_tx_tick) w_tx_nst = DATA;
      DATA: if (w_tx_tick) begin
        w_tx_nbit = r_tx_bit + 1'b1;
        if (r_tx_bit == 3'd7) w_tx_nst = STOP;
      end
      default: if (w_tx_tick) begin
        w_tx_nst = IDLE;
        w_tx_fin = 1'b1;
      end
    endcase
  end
  // Receiver counts down; the start bit is re-checked half a bit after the falling edge.
  always_comb begin
    w_rx_nst  = r_rx_st;
    w_rx_ncnt = r_rx_cnt - 1'b1;
    w_rx_nbit = r_rx_bit;
    w_rx_nsh  = r_rx_sh;
    w_rx_done = 1'b0;
    case (r_rx_st)
      IDLE: begin
        w_rx_ncnt = CW'(BAUD_DIV / 2);
        if (w_rx_fall) w_rx_nst = START;
      end
      START: if (w_rx_tick) begin
        w_rx_ncnt = CW'(BAUD_DIV - 1);
        w_rx_nst  = r_s2 ? IDLE : DATA;
      end
      DATA: if (w_rx_tick) begin
        w_rx_ncnt = CW'(BAUD_DIV - 1);
        w_rx_nsh  = {r_s2, r_rx_sh[7:1]};
        w_rx_nbit = r_rx_bit + 1'b1;
        if (r_rx_bit == 3'd7) w_rx_nst = STOP;
      end
      default: if (w_rx_tick) begin
        w_rx_nst  = IDLE;
        w_rx_done = r_s2;
      end
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tx_st <= IDLE;
      r_tx_cnt <= '0;
      r_tx_bit <= '0;
      r_tx_data <= '0;
      r_rx_st <= IDLE;
      r_rx_cnt <= '0;
      r_rx_bit <= '0;
      r_rx_sh <= '0;
      r_rx_data <= '0;
      {r_s1, r_s2, r_s3} <= 3'b111;
      r_en <= '0;
      r_tx_done <= 1'b0;
      r_rx_valid <= 1'b0;
      r_ovr <= 1'b0;
      r_irq <= 1'b0;
    end else begin
      r_tx_st <= w_tx_nst;
      r_tx_cnt <= w_tx_ncnt;
      r_tx_bit <= w_tx_nbit;
      if (w_tx_go) r_tx_data <= wdata[7:0];
      r_rx_st <= w_rx_nst;
      r_rx_cnt <= w_rx_ncnt;
      r_rx_bit <= w_rx_nbit;
      r_rx_sh <= w_rx_nsh;
      if (w_rx_done) r_rx_data <= r_rx_sh;
      {r_s1, r_s2, r_s3} <= {uart_rx, r_s1, r_s2};
      if (wr & w_con_hit) r_en <= wdata[1:0];
      r_tx_done <= w_tx_fin | (r_tx_done & ~w_con_rd);
      r_rx_valid <= w_rx_done | (r_rx_valid & ~w_rxd_rd);
      r_ovr <= (w_rx_done & r_rx_valid & ~w_rxd_rd) | (r_ovr & ~w_con_rd);
      r_irq <= (r_en[0] & r_tx_done) | (r_en[1] & r_rx_valid);
    end
  end
endmodule

// File: tb/tb_uart_mmio.sv
// tb_uart_mmio: register-table vectors, TX/RX frame sequences and randomized traffic against a byte-level model.
module tb_uart_mmio;
  localparam int D = 8;
  localparam logic [31:0] TXD = 32'h40000018, RXD = TXD + 32'd4, CON = TXD + 32'd8;
  logic clk = 1'b0, reset = 1'b1, rd = 1'b0, wr = 1'b0, uart_rx = 1'b1;
  logic [31:0] addr = '0, wdata = '0, rdata;
  logic uart_tx, irq;
  int total = 0, bad = 0;
  logic [7:0] m_data = '0;
  logic m_valid = 1'b0, m_ovr = 1'b0;
  logic [1:0] m_en = '0;
  typedef struct packed {logic r; logic w; logic [31:0] a; logic [31:0] d; logic [31:0] exp;} vec_t;
  vec_t tbl [12];

  uart_mmio #(.BAUD_DIV(D), .BASE(TXD)) dut (
    .clk(clk), .reset(reset), .rd(rd), .wr(wr), .addr(addr), .wdata(wdata),
    .rdata(rdata), .uart_rx(uart_rx), .uart_tx(uart_tx), .irq(irq)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic peek(input logic [31:0] a, output logic [31:0] d);
    rd = 1'b1;
    addr = a;
    #1;
    d = rdata;
    rd = 1'b0;
  endtask

  task automatic rd_reg(input logic [31:0] a, output logic [31:0] d);
    rd = 1'b1;
    addr = a;
    #1;
    d = rdata;
    tick();
    rd = 1'b0;
  endtask

  task automatic wr_reg(input logic [31:0] a, input logic [31:0] d);
    wr = 1'b1;
    addr = a;
    wdata = d;
    tick();
    wr = 1'b0;
  endtask

  function automatic logic frame_bit(input logic [7:0] b, input int k);
    return (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
  endfunction

  // Entered just after the edge that accepted the TXD write.
  task automatic check_frame(input logic [7:0] b, input bit busy);
    logic [31:0] d;
    for (int c = 0; c < 10 * D; c++) begin
      if (c % D == D / 2) chk($sformatf("txbit%0d", c / D), uart_tx, frame_bit(b, c / D));
      if (busy && c == 9) begin
        wr = 1'b1;
        addr = TXD;
        wdata = 32'h3C;
      end
      if (c == 10) wr = 1'b0;
      if (c == 40 || c == 10 * D - 1) begin
        peek(CON, d);
        chk("tx_busy", d[4], 1);
        chk("tx_done_early", d[2], 0);
      end
      if (c == 40) begin
        peek(TXD, d);
        chk("txd_readback", d, {24'h0, b});
      end
      tick();
    end
  endtask

  task automatic send(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      uart_rx = f[i];
      repeat (D) tick();
    end
    uart_rx = 1'b1;
    repeat (4) tick();
    if (stop) begin
      m_ovr = m_ovr | m_valid;
      m_valid = 1'b1;
      m_data = b;
    end
  endtask

  task automatic check_rx(input string nm);
    logic [31:0] d;
    peek(RXD, d);
    chk({nm, "_rxd"}, d, {24'h0, m_data});
    peek(CON, d);
    chk({nm, "_con"}, d, {26'h0, m_ovr, 1'b0, m_valid, 1'b0, m_en});
    chk({nm, "_irq"}, irq, m_en[1] & m_valid);
  endtask

  initial begin
    logic [31:0] d;
    logic [7:0] b;
    logic st;
    bit found, stayed;
    tbl[0]  = '{1'b1, 1'b0, CON, 32'h0, 32'h0};
    tbl[1]  = '{1'b1, 1'b0, TXD, 32'h0, 32'h0};
    tbl[2]  = '{1'b1, 1'b0, RXD, 32'h0, 32'h0};
    tbl[3]  = '{1'b1, 1'b0, TXD + 32'd12, 32'h0, 32'h0};
    tbl[4]  = '{1'b1, 1'b0, TXD + 32'd1, 32'h0, 32'h0};
    tbl[5]  = '{1'b0, 1'b1, CON, 32'h3, 32'h0};
    tbl[6]  = '{1'b1, 1'b0, CON, 32'h0, 32'h3};
    tbl[7]  = '{1'b0, 1'b0, CON, 32'h0, 32'h0};
    tbl[8]  = '{1'b1, 1'b1, CON, 32'hFFFFFFFE, 32'h3};
    tbl[9]  = '{1'b1, 1'b0, CON, 32'h0, 32'h2};
    tbl[10] = '{1'b0, 1'b1, CON, 32'h0, 32'h0};
    tbl[11] = '{1'b1, 1'b0, CON, 32'h0, 32'h0};
    repeat (3) tick();
    chk("rst_tx", uart_tx, 1);
    chk("rst_irq", irq, 0);
    reset = 1'b0;
    tick();
    for (int i = 0; i < 12; i++) begin
      rd = tbl[i].r;
      wr = tbl[i].w;
      addr = tbl[i].a;
      wdata = tbl[i].d;
      #1;
      chk($sformatf("vec%0d", i), rdata, tbl[i].exp);
      tick();
    end
    rd = 1'b0;
    wr = 1'b0;
    // Reset in the middle of a transmit frame
    wr_reg(TXD, 32'h55);
    repeat (20) tick();
    chk("tx_mid_frame", uart_tx, 0);
    #2 reset = 1'b1;
    #1 chk("rst_async_tx", uart_tx, 1);
    tick();
    reset = 1'b0;
    tick();
    peek(CON, d);
    chk("rst_con", d, 32'h0);
    peek(TXD, d);
    chk("rst_txd", d, 32'h0);
    // Full frame with tx interrupt
    wr_reg(CON, 32'h1);
    m_en = 2'b01;
    wr_reg(TXD, 32'hA5);
    chk("tx_first_start", uart_tx, 0);
    check_frame(8'hA5, 1'b0);
    peek(CON, d);
    chk("tx_done_con", d, 32'h05);
    chk("irq_lag", irq, 0);
    tick();
    chk("irq_set", irq, 1);
    rd_reg(CON, d);
    chk("con_read_clr", d, 32'h05);
    chk("irq_hold", irq, 1);
    tick();
    chk("irq_drop", irq, 0);
    peek(CON, d);
    chk("con_after_clr", d, 32'h01);
    // Write while busy is ignored
    wr_reg(TXD, 32'hA5);
    check_frame(8'hA5, 1'b1);
    peek(TXD, d);
    chk("busy_txd", d, 32'hA5);
    stayed = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (uart_tx !== 1'b1) stayed = 1'b0;
      tick();
    end
    chk("no_second_frame", stayed, 1);
    rd_reg(CON, d);
    chk("busy_con", d, 32'h05);
    for (int i = 0; i < 3; i++) begin
      b = 8'($urandom);
      wr_reg(TXD, {24'h0, b});
      check_frame(b, 1'($urandom_range(0, 1)));
      rd_reg(CON, d);
      chk($sformatf("rndtx%0d_con", i), d, 32'h05);
    end
    // Receive path
    wr_reg(CON, 32'h2);
    m_en = 2'b10;
    tick();
    send(8'h3C, 1'b1);
    check_rx("rx1");
    rd_reg(RXD, d);
    chk("rx1_read", d, 32'h3C);
    m_valid = 1'b0;
    tick();
    check_rx("rx1_clr");
    send(8'h11, 1'b1);
    send(8'h22, 1'b1);
    check_rx("ovr");
    rd_reg(CON, d);
    chk("ovr_read", d, 32'h2A);
    m_ovr = 1'b0;
    check_rx("ovr_clr");
    send(8'h77, 1'b0);
    check_rx("framing");
    rd_reg(RXD, d);
    m_valid = 1'b0;
    tick();
    uart_rx = 1'b0;
    repeat (2) tick();
    uart_rx = 1'b1;
    repeat (30) tick();
    check_rx("glitch");
    // Byte completes on the same edge as an RXD read
    found = 1'b0;
    fork
      send(8'h5A, 1'b1);
      begin
        repeat (60) tick();
        rd = 1'b1;
        addr = RXD;
        for (int i = 0; i < 40 && !found; i++) begin
          tick();
          if (rdata[7:0] == 8'h5A) begin
            found = 1'b1;
            rd = 1'b0;
          end
        end
        rd = 1'b0;
      end
    join
    chk("simul_seen", found, 1);
    check_rx("simul");
    rd_reg(RXD, d);
    m_valid = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) begin
      b = 8'($urandom);
      st = ($urandom_range(0, 3) != 0);
      send(b, st);
      check_rx($sformatf("rnd%0d", i));
      case ($urandom_range(0, 2))
        1: begin
          rd_reg(RXD, d);
          chk($sformatf("rnd%0d_rd", i), d, {24'h0, m_data});
          m_valid = 1'b0;
          tick();
        end
        2: begin
          rd_reg(CON, d);
          chk($sformatf("rnd%0d_con_rd", i), d, {26'h0, m_ovr, 1'b0, m_valid, 1'b0, m_en});
          m_ovr = 1'b0;
          tick();
        end
        default: ;
      endcase
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
